// File: rtl/count_checker.sv
// Monitors an upstream free-running counter, locks onto a +1 sequence and flags deviations.
// Optional macro COUNT_CHECKER_HOLD_EN: a repeated value (count_in == prev) is treated as legal.
module count_checker #(
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 2,
  parameter int STAT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              enable,
  input  logic              clear,
  output logic              locked,
  output logic              error,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] wrap_count,
  output logic [STAT_W-1:0] err_count
);

  localparam int RUN_W = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0]  COUNT_MAX = {WIDTH{1'b1}};
  localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;

  logic [WIDTH-1:0] expected;
  logic [RUN_W-1:0] run_inc;
  logic             step_ok;
  logic             hold_ok;

  assign expected = prev + WIDTH'(1);
  assign run_inc  = run + RUN_W'(1);
  assign step_ok  = (count_in == expected);

`ifdef COUNT_CHECKER_HOLD_EN
  assign hold_ok = (count_in == prev);
`else
  assign hold_ok = 1'b0;
`endif

  // clear is applied after the state-dependent updates so it wins over any increment or error-set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;

      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        prev <= count_in;
        case (state)
          IDLE: begin
            run    <= '0;
            state  <= SYNC;
            locked <= 1'b0;
          end

          SYNC: begin
            if (step_ok) begin
              run <= run_inc;
              if (run_inc == RUN_LOCK) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (!hold_ok) begin
              run <= '0;
            end
          end

          LOCKED: begin
            if (step_ok) begin
              if (prev == COUNT_MAX) begin
                wrap_pulse <= 1'b1;
                if (wrap_count != STAT_MAX)
                  wrap_count <= wrap_count + STAT_W'(1);
              end
            end else if (!hold_ok) begin
              err_pulse <= 1'b1;
              error     <= 1'b1;
              if (err_count != STAT_MAX)
                err_count <= err_count + STAT_W'(1);
              run    <= '0;
              state  <= SYNC;
              locked <= 1'b0;
            end
          end

          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      if (clear) begin
        wrap_count <= '0;
        err_count  <= '0;
        error      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed self-checking bench for count_checker with default parameters (WIDTH=3, LOCK_LEN=2, STAT_W=8).
module tb_count_checker;

  logic       clock;
  logic       reset;
  logic [2:0] count_in;
  logic       enable;
  logic       clear;
  logic       locked;
  logic       error;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic [7:0] err_count;

  int checks;
  int errors;
  int exp_err;
  int exp_wrap;
  logic [2:0] cur;

  count_checker dut (
    .clock      (clock),
    .reset      (reset),
    .count_in   (count_in),
    .enable     (enable),
    .clear      (clear),
    .locked     (locked),
    .error      (error),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_count  (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // present a sample, let the DUT take it on the next rising edge, return 1 time unit later
  task automatic drive(input logic [2:0] v);
    count_in = v;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; count_in = 3'd0;
    #1;
    checks++;
    if ({locked, error, err_pulse, wrap_pulse, wrap_count, err_count} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {locked, error, err_pulse, wrap_pulse, wrap_count, err_count});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL idle_locked: got %b want 0", locked);
    end
  endtask

  task automatic test_lock_wrap;
    enable = 1'b1;
    drive(3'd0);
    drive(3'd1);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL early_lock: got %b want 0", locked);
    end
    drive(3'd2);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_after_2: got %b want 1", locked);
    end
    for (int v = 3; v <= 7; v++) begin
      drive(3'(v));
      checks++;
      if (wrap_pulse !== 1'b0) begin
        errors++; $display("FAIL early_wrap at %0d: got %b want 0", v, wrap_pulse);
      end
    end
    drive(3'd0);
    exp_wrap = 1;
    checks++;
    if (wrap_pulse !== 1'b1 || wrap_count !== 8'(exp_wrap)) begin
      errors++;
      $display("FAIL wrap_7_to_0: got pulse=%b count=%0d want pulse=1 count=%0d",
               wrap_pulse, wrap_count, exp_wrap);
    end
    drive(3'd1);
    checks++;
    if (wrap_pulse !== 1'b0 || wrap_count !== 8'(exp_wrap) || error !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL after_wrap: got pulse=%b count=%0d error=%b locked=%b want 0 %0d 0 1",
               wrap_pulse, wrap_count, error, locked, exp_wrap);
    end
  endtask

  task automatic test_mismatch;
    drive(3'd2);
    drive(3'd3);
    drive(3'd5);
    exp_err = 1;
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'(exp_err) || error !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL mismatch: got pulse=%b cnt=%0d error=%b locked=%b want 1 %0d 1 0",
               err_pulse, err_count, error, locked, exp_err);
    end
    drive(3'd6);
    checks++;
    if (err_pulse !== 1'b0 || error !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: got pulse=%b error=%b locked=%b want 0 1 0",
               err_pulse, error, locked);
    end
    drive(3'd7);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL relock_7: got %b want 1", locked);
    end
    drive(3'd0);
    exp_wrap = 2;
    checks++;
    if (locked !== 1'b1 || wrap_pulse !== 1'b1 || wrap_count !== 8'(exp_wrap)) begin
      errors++;
      $display("FAIL relock_wrap: got locked=%b pulse=%b count=%0d want 1 1 %0d",
               locked, wrap_pulse, wrap_count, exp_wrap);
    end
  endtask

  task automatic test_hold;
    logic exp_locked;
    drive(3'd1); drive(3'd2); drive(3'd3); drive(3'd4);
    drive(3'd4);
`ifdef COUNT_CHECKER_HOLD_EN
    exp_locked = 1'b1;
`else
    exp_err    = exp_err + 1;
    exp_locked = 1'b0;
`endif
    checks++;
    if (err_count !== 8'(exp_err) || locked !== exp_locked) begin
      errors++;
      $display("FAIL hold: got cnt=%0d locked=%b want %0d %b",
               err_count, locked, exp_err, exp_locked);
    end
    drive(3'd5);
    drive(3'd6);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL hold_relock: got %b want 1", locked);
    end
  endtask

  task automatic test_clear;
    drive(3'd7);
    clear = 1'b1;
    drive(3'd2);
    clear = 1'b0;
    exp_err  = 0;
    exp_wrap = 0;
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd0 || error !== 1'b0 ||
        wrap_count !== 8'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: got pulse=%b cnt=%0d error=%b wraps=%0d locked=%b want 1 0 0 0 0",
               err_pulse, err_count, error, wrap_count, locked);
    end
    drive(3'd3);
    drive(3'd4);
    checks++;
    if (locked !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL clear_relock: got locked=%b error=%b want 1 0", locked, error);
    end
    cur = 3'd4;
  endtask

  task automatic test_saturation;
    int want;
    for (int i = 0; i < 300; i++) begin
      cur = cur + 3'd3;
      drive(cur);
      want = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (err_count !== 8'(want) || err_pulse !== 1'b1) begin
        errors++;
        $display("FAIL saturation[%0d]: got cnt=%0d pulse=%b want %0d 1",
                 i, err_count, err_pulse, want);
      end
      cur = cur + 3'd1; drive(cur);
      cur = cur + 3'd1; drive(cur);
    end
    checks++;
    if (err_count !== 8'd255 || locked !== 1'b1 || wrap_count !== 8'(exp_wrap)) begin
      errors++;
      $display("FAIL saturation_hold: got cnt=%0d locked=%b wraps=%0d want 255 1 %0d",
               err_count, locked, wrap_count, exp_wrap);
    end
  endtask

  task automatic test_async_reset;
    while (exp_wrap < 5) begin
      if (cur == 3'd7) exp_wrap++;
      cur = cur + 3'd1;
      drive(cur);
    end
    checks++;
    if (wrap_count !== 8'd5 || wrap_pulse !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL five_wraps: got wraps=%0d pulse=%b locked=%b want 5 1 1",
               wrap_count, wrap_pulse, locked);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({locked, error, err_pulse, wrap_pulse, wrap_count, err_count} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset: got %b, want all zero before next edge",
               {locked, error, err_pulse, wrap_pulse, wrap_count, err_count});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    drive(3'd0);
    checks++;
    if (locked !== 1'b0 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL resume_idle: got locked=%b pulse=%b want 0 0", locked, wrap_pulse);
    end
    drive(3'd1);
    drive(3'd2);
    checks++;
    if (locked !== 1'b1 || wrap_count !== 8'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL resume_lock: got locked=%b wraps=%0d errs=%0d want 1 0 0",
               locked, wrap_count, err_count);
    end
  endtask

  task automatic test_disable;
    enable = 1'b0;
    drive(3'd5);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL disable_idle: got locked=%b want 0", locked);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_err  = 0;
    exp_wrap = 0;
    cur      = 3'd0;
    test_reset();
    test_lock_wrap();
    test_mismatch();
    test_hold();
    test_clear();
    test_saturation();
    test_async_reset();
    test_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
